mem_write_encoder: RTL
======================

Name: mem_write_encoder

Overview:
- Store-side counterpart of the load-data decoder. Takes one RISC-V store request (SB/SH/SW, byte address, unshifted rs2 data).
- Produces word-aligned memory write beats with a 4-bit byte-write mask and lane-aligned write data.
- Registered, valid/ready on both sides. Sits between the EX/MEM stage and the DMEM/IO write port.
- Misaligned stores that cross a word boundary are split into two beats when MEM_WRITE_SPLIT_EN is defined.

Parameters:
- ADDR_WIDTH, 32, byte-address width of req_addr and mem_addr.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  store request valid.
- req_ready  output  1  encoder can accept a request this cycle.
- req_fnc  input  3  funct3 from Opcode.vh: FNC_SB=000, FNC_SH=001, FNC_SW=010.
- req_addr  input  ADDR_WIDTH  byte address.
- req_data  input  32  store data, right-justified.
- mem_valid  output  1  write beat valid.
- mem_ready  input  1  memory accepts the beat.
- mem_addr  output  ADDR_WIDTH  word-aligned address; bits [1:0] always 00.
- mem_wdata  output  32  lane-aligned write data.
- mem_we  output  4  byte-write mask; bit i enables mem_wdata[8i+7:8i].
- misaligned  output  1  current beat belongs to a word-crossing store.
- busy  output  1  state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; mem_valid, mem_we, mem_wdata, mem_addr, misaligned all 0; busy 0.
- A reset asserted mid-operation drops any pending beat. Nothing is written after the reset edge.
- FSM states: IDLE, BEAT0, BEAT1.
- req_ready = (state==IDLE) OR (mem_valid AND mem_ready AND the current beat is the last beat). This is a combinational path from mem_ready and is accepted.
- Accept: req_valid AND req_ready. On the next edge, beat0 is registered and the state moves to BEAT0.
- Latency: one cycle from accept to mem_valid.
- Throughput: 1 store per cycle when no split is needed and mem_ready stays high.
- Encoding, with off = req_addr[1:0]:
  - Base mask: SB=0001, SH=0011, SW=1111.
  - Wide mask = {4'b0, base} << off (8 bits).
  - beat0: we = wide[3:0]; addr = {req_addr[ADDR_WIDTH-1:2], 2'b00}.
  - beat1: we = wide[7:4]; addr = beat0 addr + 4, wrapping modulo 2^ADDR_WIDTH.
  - Rotated data = req_data rotated left by 8*off bits (32-bit rotate).
  - mem_wdata = rotated data with every lane whose we bit is 0 forced to 0 (deterministic output).
- A split is needed iff wide[7:4] != 0, i.e. SH with off=3 or SW with off!=0.
- Holding rule: while mem_valid=1 and mem_ready=0, all mem_* outputs and misaligned stay stable.
- BEAT0 on mem_ready:
  - Split needed: go to BEAT1 and present beat1.
  - Otherwise: go to IDLE, or reload BEAT0 if a new request is accepted the same cycle.
- BEAT1 on mem_ready: go to IDLE, or reload BEAT0 on a simultaneous accept.
- Illegal req_fnc (011–111): request is accepted and discarded. No beat is issued and the state stays IDLE, or returns to IDLE if it was completing a beat.
- misaligned is 1 on both beats of a crossing store and 0 otherwise.

Optional Feature:
- Macro: MEM_WRITE_SPLIT_EN.
- Defined: crossing stores are issued as two beats, as above.
- Undefined:
  - BEAT1 is never entered; only beat0 is issued.
  - The overflow bytes of a crossing store are dropped.
  - misaligned = 1 on that single beat.
  - Mask and data rules are otherwise unchanged.

Decomposition:
- Shared header mem_access.vh: FSM state encodings, base-mask constants MASK_B/MASK_H/MASK_W. funct3 constants are reused from Opcode.vh.
- One combinational sub-module, store_lane_encoder. Inputs: fnc, off, data. Outputs: we0, we1, rotated/masked data, split, illegal.
- The top module keeps the FSM, output registers and handshake.

Test Plan:
1. SW to addr 0x100, data 0xDEADBEEF, mem_ready=1 -> next cycle one beat: addr 0x100, we 1111, wdata 0xDEADBEEF, misaligned 0.
2. SB to 0x203, data 0x000000A5 -> addr 0x200, we 1000, wdata 0xA5000000. SH to 0x102, data 0x1234 -> we 1100, wdata 0x12340000.
3. SPLIT_EN defined: SW to 0x101, data 0x11223344 -> beat0 addr 0x100, we 1110, wdata 0x22334400; beat1 addr 0x104, we 0001, wdata 0x00000011; misaligned=1 on both. Undefined: beat0 only.
4. Back-pressure: mem_ready held 0 for 3 cycles -> outputs stable, req_ready 0. Then back-to-back SB/SB/SB with mem_ready=1 -> one beat per cycle.
5. Wrap: SH to 0xFFFFFFFF, data 0xABCD (SPLIT_EN) -> beat0 addr 0xFFFFFFFC, we 1000, wdata 0xCD000000; beat1 addr 0x00000000, we 0001, wdata 0x000000AB.
6. rst asserted while BEAT0 is stalled -> next cycle mem_valid 0, busy 0. Illegal fnc 011 accepted -> no beat.

Source files
------------

// File: rtl/mem_write_encoder_pkg.sv
// mem_write_encoder_pkg: FSM states, funct3 codes, base byte masks and lane helpers for the store encoder
package mem_write_encoder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;
  localparam logic [2:0] FNC_SB = 3'b000;
  localparam logic [2:0] FNC_SH = 3'b001;
  localparam logic [2:0] FNC_SW = 3'b010;
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;
  function automatic logic [3:0] base_mask(input logic [2:0] fnc);
    return fnc == FNC_SB ? MASK_B : fnc == FNC_SH ? MASK_H : fnc == FNC_SW ? MASK_W : 4'b0000;
  endfunction
  function automatic logic [31:0] lane_mask(input logic [3:0] we);
    return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction
endpackage

// File: rtl/mem_write_encoder_if.sv
// mem_write_encoder_if: store request and memory write-beat handshake bundle
interface mem_write_encoder_if #(parameter int ADDR_WIDTH = 32);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_fnc;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_we;
  logic                  misaligned;
  logic                  busy;
  modport master (
    output req_valid, req_fnc, req_addr, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_we, misaligned, busy
  );
  modport slave (
    input  req_valid, req_fnc, req_addr, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_we, misaligned, busy
  );
endinterface

// File: rtl/mem_write_encoder_lane.sv
// mem_write_encoder_lane: combinational store lane encoder (masks, rotated/masked data, split, illegal)
module mem_write_encoder_lane
  import mem_write_encoder_pkg::*;
(
  input  logic [2:0]  fnc,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [3:0]  we0,
  output logic [3:0]  we1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic        split,
  output logic        illegal
);
  logic [7:0]  wide;
  logic [31:0] rot;
  assign wide    = {4'b0000, base_mask(fnc)} << off;
  assign we0     = wide[3:0];
  assign we1     = wide[7:4];
  assign split   = |wide[7:4];
  assign illegal = fnc > FNC_SW;
  assign rot     = off == 2'd0 ? data :
                   off == 2'd1 ? {data[23:0], data[31:24]} :
                   off == 2'd2 ? {data[15:0], data[31:16]} :
                                 {data[7:0],  data[31:8]};
  assign wdata0  = rot & lane_mask(we0);
  assign wdata1  = rot & lane_mask(we1);
endmodule

// File: rtl/mem_write_encoder.sv
// mem_write_encoder: RISC-V store to word-aligned write beats; define MEM_WRITE_SPLIT_EN to split word-crossing stores
module mem_write_encoder
  import mem_write_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  mem_write_encoder_if.slave bus
);
  state_t                state_q, state_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  misaligned_q, misaligned_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] base_addr, next_addr;
  logic [3:0]            we0, we1;
  logic [31:0]           wdata0, wdata1;
  logic                  split, illegal, fire, last, accept;
`ifdef MEM_WRITE_SPLIT_EN
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] b1_addr_q, b1_addr_d;
  logic [31:0]           b1_wdata_q, b1_wdata_d;
  logic [3:0]            b1_we_q, b1_we_d;
`else
  logic                  unused_b1;
`endif
  mem_write_encoder_lane u_lane (
    .fnc    (bus.req_fnc),
    .off    (bus.req_addr[1:0]),
    .data   (bus.req_data),
    .we0    (we0),
    .we1    (we1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .split  (split),
    .illegal(illegal)
  );
  assign base_addr = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign next_addr = base_addr + ADDR_WIDTH'(4);
  assign fire      = mem_valid_q && bus.mem_ready;
`ifdef MEM_WRITE_SPLIT_EN
  assign last      = !(state_q == BEAT0 && pend_q);
`else
  assign last      = 1'b1;
  assign unused_b1 = ^{we1, wdata1, next_addr};
`endif
  assign bus.req_ready  = state_q == IDLE || (fire && last);
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.misaligned = misaligned_q;
  assign bus.busy       = state_q != IDLE;
  // next beat: hold while stalled, advance to beat1 or retire on a handshake, load a fresh beat0 on accept
  always_comb begin
    state_d      = state_q;
    mem_valid_d  = mem_valid_q;
    misaligned_d = misaligned_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
`ifdef MEM_WRITE_SPLIT_EN
    pend_d       = pend_q;
    b1_addr_d    = b1_addr_q;
    b1_wdata_d   = b1_wdata_q;
    b1_we_d      = b1_we_q;
`endif
    if (fire) begin
      state_d      = last ? IDLE : BEAT1;
      mem_valid_d  = !last;
      misaligned_d = misaligned_q && !last;
    end
`ifdef MEM_WRITE_SPLIT_EN
    if (fire && !last) begin
      mem_addr_d  = b1_addr_q;
      mem_wdata_d = b1_wdata_q;
      mem_we_d    = b1_we_q;
      pend_d      = 1'b0;
    end
`endif
    if (accept) begin
      state_d      = illegal ? IDLE : BEAT0;
      mem_valid_d  = !illegal;
      misaligned_d = !illegal && split;
      mem_addr_d   = base_addr;
      mem_wdata_d  = wdata0;
      mem_we_d     = we0;
`ifdef MEM_WRITE_SPLIT_EN
      pend_d       = !illegal && split;
      b1_addr_d    = next_addr;
      b1_wdata_d   = wdata1;
      b1_we_d      = we1;
`endif
    end
  end
  // state and output registers, cleared by reset so no beat survives it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_valid_q  <= 1'b0;
      misaligned_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= '0;
`ifdef MEM_WRITE_SPLIT_EN
      pend_q       <= 1'b0;
      b1_addr_q    <= '0;
      b1_wdata_q   <= '0;
      b1_we_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mem_valid_q  <= mem_valid_d;
      misaligned_q <= misaligned_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
`ifdef MEM_WRITE_SPLIT_EN
      pend_q       <= pend_d;
      b1_addr_q    <= b1_addr_d;
      b1_wdata_q   <= b1_wdata_d;
      b1_we_q      <= b1_we_d;
`endif
    end
  end
endmodule
